// File: rtl/vrf_arb_pkg.sv
// Shared types for the vector register file read-port arbiter.
package vrf_arb_pkg;

    localparam int unsigned TAG_IDX_W = 4;  // response tags cover up to 16 requesters

    typedef enum logic {
        ISSUE   = 1'b0,
        ISSUE_B = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] index;
        logic                 last;
    } rsp_tag_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requester: round-robin from ptr, or lowest index when VRF_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import vrf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

`ifdef VRF_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_c && req[IDX_W'(k)]) begin
                any_c              = 1'b1;
                idx_c              = IDX_W'(k);
                gnt_c[IDX_W'(k)]   = 1'b1;
            end
        end
    end
`else
    int unsigned cand;

    // Search starts at ptr and wraps once around the requesters.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_c && req[IDX_W'(cand)]) begin
                any_c                = 1'b1;
                idx_c                = IDX_W'(cand);
                gnt_c[IDX_W'(cand)]  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vrf_read_arbiter.sv
// Shares the VRF BRAM read port among requesters; two-operand requests issue A then B back-to-back.
// Build option: VRF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module vrf_read_arbiter
    import vrf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_two,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_a,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         bram_read_addr,
    output logic                          bram_read_en,
    input  logic [DATA_WIDTH-1:0]         bram_rdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic                          busy
);

    localparam int unsigned IDX_W    = idx_width(NUM_REQ);
    localparam int unsigned LAST_IDX = NUM_REQ - 1;

    arb_state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]            b_addr_q, b_addr_d;
    logic [IDX_W-1:0]                 b_idx_q, b_idx_d;
    rsp_tag_t [READ_LATENCY-1:0]      pipe_q, pipe_d;
    rsp_tag_t [READ_LATENCY:0]        pipe_in;
    rsp_tag_t                         issue_tag;
    logic [READ_LATENCY-1:0]          pipe_vld;

    logic [ADDR_WIDTH-1:0]            addr_a_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0]            addr_b_arr [NUM_REQ];
    logic [NUM_REQ-1:0]               arb_gnt;
    logic [IDX_W-1:0]                 arb_idx;
    logic [IDX_W-1:0]                 arb_ptr;
    logic                             arb_any;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a_arr[g] = req_addr_a[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign addr_b_arr[g] = req_addr_b[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .gnt_c (arb_gnt),
        .idx_c (arb_idx),
        .any_c (arb_any)
    );

`ifdef VRF_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Next search begins just after the most recent winner.
    always_comb begin
        ptr_d = ptr_q;
        if (!rst && (state_q == ISSUE) && arb_any) begin
            ptr_d = (arb_idx == IDX_W'(LAST_IDX)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    // Issue control: grant/address are combinational; B issue is never preempted.
    always_comb begin
        state_d        = state_q;
        b_addr_d       = b_addr_q;
        b_idx_d        = b_idx_q;
        req_ready      = '0;
        bram_read_en   = 1'b0;
        bram_read_addr = '0;
        issue_tag      = '0;
        if (!rst) begin
            case (state_q)
                ISSUE: begin
                    if (arb_any) begin
                        req_ready       = arb_gnt;
                        bram_read_en    = 1'b1;
                        bram_read_addr  = addr_a_arr[arb_idx];
                        issue_tag.valid = 1'b1;
                        issue_tag.index = TAG_IDX_W'(arb_idx);
                        issue_tag.last  = !req_two[arb_idx];
                        if (req_two[arb_idx]) begin
                            b_addr_d = addr_b_arr[arb_idx];
                            b_idx_d  = arb_idx;
                            state_d  = ISSUE_B;
                        end
                    end
                end
                ISSUE_B: begin
                    bram_read_en    = 1'b1;
                    bram_read_addr  = b_addr_q;
                    issue_tag.valid = 1'b1;
                    issue_tag.index = TAG_IDX_W'(b_idx_q);
                    issue_tag.last  = 1'b1;
                    state_d         = ISSUE;
                end
            endcase
        end
    end

    // Tag pipe mirrors BRAM latency; stage 0 takes the current issue.
    assign pipe_in = {pipe_q, issue_tag};

    always_comb begin
        pipe_d = pipe_in[READ_LATENCY-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ISSUE;
            b_addr_q <= '0;
            b_idx_q  <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            b_addr_q <= b_addr_d;
            b_idx_q  <= b_idx_d;
            pipe_q   <= pipe_d;
        end
    end

    for (genvar s = 0; s < READ_LATENCY; s++) begin : g_vld
        assign pipe_vld[s] = pipe_q[s].valid;
    end

    logic unused_tag;
    assign unused_tag = ^{pipe_in[READ_LATENCY], pipe_q[READ_LATENCY-1].index};

    always_comb begin
        rsp_valid = '0;
        if (pipe_q[READ_LATENCY-1].valid) begin
            rsp_valid[IDX_W'(pipe_q[READ_LATENCY-1].index)] = 1'b1;
        end
    end

    assign rsp_last = pipe_q[READ_LATENCY-1].valid & pipe_q[READ_LATENCY-1].last;
    assign rsp_data = bram_rdata;
    assign busy     = (state_q == ISSUE_B) | (|pipe_vld);

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Bench for vrf_read_arbiter: two instances (read latency 1 and 3) against a transaction-level model.
module tb_vrf_read_arbiter;
    import vrf_arb_pkg::*;

    localparam int unsigned N     = 3;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 128;
    localparam int unsigned LAT1  = 1;
    localparam int unsigned LAT3  = 3;

    typedef struct {
        bit             v;
        int             own;
        bit             last;
        logic [AW-1:0]  addr;
    } iss_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_two;
    logic [N*AW-1:0] req_addr_a, req_addr_b;

    logic [N-1:0]    rdy1, rvld1, rdy3, rvld3;
    logic [AW-1:0]   raddr1, raddr3;
    logic            ren1, rlast1, busy1, ren3, rlast3, busy3;
    logic [DW-1:0]   rdata1, rdat1, rdata3, rdat3, d3a, d3b;

    logic [DW-1:0]   mem [32];

    bit              v   [N];
    bit              two [N];
    logic [AW-1:0]   aa  [N];
    logic [AW-1:0]   ab  [N];

    bit              b_pend;
    logic [AW-1:0]   b_addr;
    int              b_own;
    int              rr_next;
    iss_t            h [4];
    logic [N-1:0]    last_rdy;

    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    vrf_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_two(req_two),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_ready(rdy1),
        .bram_read_addr(raddr1), .bram_read_en(ren1), .bram_rdata(rdata1),
        .rsp_valid(rvld1), .rsp_data(rdat1), .rsp_last(rlast1), .busy(busy1)
    );

    vrf_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_two(req_two),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_ready(rdy3),
        .bram_read_addr(raddr3), .bram_read_en(ren3), .bram_rdata(rdata3),
        .rsp_valid(rvld3), .rsp_data(rdat3), .rsp_last(rlast3), .busy(busy3)
    );

    // BRAM models with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        if (ren1) rdata1 <= mem[raddr1];
        if (ren3) d3a <= mem[raddr3];
        d3b    <= d3a;
        rdata3 <= d3b;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        b_pend  = 1'b0;
        b_addr  = '0;
        b_own   = 0;
        rr_next = 0;
        for (int k = 0; k < 4; k++) h[k] = '{v: 1'b0, own: 0, last: 1'b0, addr: '0};
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; two[i] = 1'b0; aa[i] = '0; ab[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input bit t, input logic [AW-1:0] a, input logic [AW-1:0] b);
        v[i] = 1'b1; two[i] = t; aa[i] = a; ab[i] = b;
    endtask

    task automatic check_rsp(input string nm, input int lat, input logic [N-1:0] vld,
                             input logic lst, input logic bsy, input logic [DW-1:0] dat);
        iss_t e;
        bit   any;
        e   = h[lat-1];
        any = b_pend;
        for (int k = 0; k < lat; k++) any = any | h[k].v;
        chk({nm, "_rsp_valid"}, DW'(vld), e.v ? DW'(1 << e.own) : '0);
        chk({nm, "_rsp_last"},  DW'(lst), DW'(e.v & e.last));
        chk({nm, "_busy"},      DW'(bsy), DW'(any));
        if (e.v) chk({nm, "_rsp_data"}, dat, mem[e.addr]);
    endtask

    // One cycle: drive inputs, check against the model, then advance the model.
    task automatic do_cycle();
        logic [N-1:0]  e_rdy;
        logic          e_en;
        logic [AW-1:0] e_addr;
        iss_t          iss;
        int            win;
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = v[i];
            req_two[i]               = two[i];
            req_addr_a[i*AW +: AW]   = aa[i];
            req_addr_b[i*AW +: AW]   = ab[i];
        end
        #1;
        if (rst) model_reset();
        e_rdy  = '0;
        e_en   = 1'b0;
        e_addr = '0;
        iss    = '{v: 1'b0, own: 0, last: 1'b0, addr: '0};
        win    = -1;
        if (!rst) begin
            if (b_pend) begin
                e_en   = 1'b1;
                e_addr = b_addr;
                iss    = '{v: 1'b1, own: b_own, last: 1'b1, addr: b_addr};
            end else begin
                for (int k = 0; k < N; k++) begin
`ifdef VRF_ARB_FIXED_PRIO_EN
                    int c = k;
`else
                    int c = (rr_next + k) % N;
`endif
                    if (win < 0 && v[c]) win = c;
                end
                if (win >= 0) begin
                    e_rdy[win] = 1'b1;
                    e_en       = 1'b1;
                    e_addr     = aa[win];
                    iss        = '{v: 1'b1, own: win, last: !two[win], addr: aa[win]};
                end
            end
        end
        chk("l1_req_ready", DW'(rdy1),   DW'(e_rdy));
        chk("l1_read_en",   DW'(ren1),   DW'(e_en));
        chk("l1_read_addr", DW'(raddr1), DW'(e_addr));
        chk("l3_req_ready", DW'(rdy3),   DW'(e_rdy));
        chk("l3_read_addr", DW'(raddr3), DW'(e_addr));
        check_rsp("l1", LAT1, rvld1, rlast1, busy1, rdat1);
        check_rsp("l3", LAT3, rvld3, rlast3, busy3, rdat3);
        last_rdy = rdy1;
        for (int k = 3; k > 0; k--) h[k] = h[k-1];
        h[0] = iss;
        if (!rst) begin
            if (b_pend) begin
                b_pend = 1'b0;
            end else if (win >= 0) begin
                rr_next = (win + 1) % N;
                if (two[win]) begin
                    b_pend = 1'b1;
                    b_addr = ab[win];
                    b_own  = win;
                end
                v[win] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            do_cycle();
        end
    endtask

    initial begin
        logic [N-1:0] seq [6];
`ifdef VRF_ARB_FIXED_PRIO_EN
        seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        for (int i = 0; i < 32; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem[7] = 128'hA5;
        clear_reqs();
        model_reset();
        rst = 1'b1;
        req_valid = '0; req_two = '0; req_addr_a = '0; req_addr_b = '0;

        // Reset values, then idle.
        run(2);
        @(negedge clk); rst = 1'b0; do_cycle();

        // Single-operand request from req1 at address 7.
        @(negedge clk); set_req(1, 1'b0, 5'd7, 5'd0); do_cycle();
        chk("t1_grant", DW'(last_rdy), DW'(3'b010));
        @(negedge clk); do_cycle();
        chk("t1_rsp_valid", DW'(rvld1), DW'(3'b010));
        chk("t1_rsp_data",  rdat1, 128'hA5);
        run(4);

        // Two-operand request from req0: A=3, B=9.
        @(negedge clk); set_req(0, 1'b1, 5'd3, 5'd9); do_cycle();
        @(negedge clk); do_cycle();
        chk("t2_b_addr",   DW'(raddr1), DW'(5'd9));
        chk("t2_no_grant", DW'(rdy1),   '0);
        chk("t2_a_last",   DW'(rlast1), '0);
        run(4);

        // All requesters continuously valid after a fresh reset.
        @(negedge clk); rst = 1'b1; do_cycle();
        @(negedge clk); rst = 1'b0; do_cycle();
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'($urandom_range(0, 31)), 5'd0);
            do_cycle();
            chk("grant_seq", DW'(last_rdy), DW'(seq[s]));
        end
        clear_reqs();
        run(4);

        // Two-operand grant then single grant two cycles later.
        @(negedge clk); set_req(0, 1'b1, 5'd4, 5'd5); do_cycle();
        @(negedge clk); do_cycle();
        @(negedge clk); set_req(2, 1'b0, 5'd6, 5'd0); do_cycle();
        run(5);

        // Reset the cycle after a two-operand grant.
        @(negedge clk); set_req(1, 1'b1, 5'd12, 5'd13); do_cycle();
        @(negedge clk); rst = 1'b1; clear_reqs(); do_cycle();
        chk("rst_busy", DW'(busy3), '0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 20), 5'd0);
        do_cycle();
        chk("rst_first_grant", DW'(last_rdy), DW'(3'b001));
        clear_reqs();
        run(5);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 99) < 55) begin
                    set_req(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 31)),
                            AW'($urandom_range(0, 31)));
                end else if (v[i] && $urandom_range(0, 99) < 4) begin
                    v[i] = 1'b0;
                end
            end
            do_cycle();
        end
        @(negedge clk); rst = 1'b0; clear_reqs(); do_cycle();
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
